// File: rtl/iob_merge_rr_pkg.sv
// -----------------------------------------------------------------------------
// iob_merge_rr_pkg
// Shared definitions for the round-robin native-bus merge and its arbiter:
//   - merge FSM state encoding (ST_IDLE, ST_BUSY)
//   - width helpers for the packed request {valid, addr, wdata, wstrb}
//     and response {rdata, ready} words
//   - select-index width helper (at least one bit, even for one master)
// No ports; imported by iob_rr_arbiter and iob_merge_rr.
// -----------------------------------------------------------------------------
package iob_merge_rr_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } merge_state_t;

    // Request word: valid bit on top, then address, write data and strobes.
    function automatic int calc_req_w(input int addrW, input int dataW);
        return 1 + addrW + dataW + dataW / 8;
    endfunction

    // Response word: read data on top, ready in bit 0.
    function automatic int calc_resp_w(input int dataW);
        return dataW + 1;
    endfunction

    // A single master still needs a one-bit index so the registers exist.
    function automatic int calc_sel_w(input int nMasters);
        return (nMasters > 1) ? $clog2(nMasters) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// -----------------------------------------------------------------------------
// iob_rr_arbiter
// Purely combinational round-robin pick. The search starts one past the last
// served master and wraps, so the most recently served master is always the
// last to be considered again.
// Ports:
//   i_req    [N-1:0]      request vector, one bit per master
//   i_last   [SEL_W-1:0]  index of the most recently served master
//   o_grant  [N-1:0]      one-hot winner (zero when nobody requests)
//   o_idx    [SEL_W-1:0]  encoded winner index
//   o_any                 at least one request is present
// -----------------------------------------------------------------------------
module iob_rr_arbiter
    import iob_merge_rr_pkg::*;
#(
    parameter int N     = 2,
    parameter int SEL_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_last,
    output logic [N-1:0]     o_grant,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    int w_dist;
    int w_bestDist;

    // Each master's priority is its distance from last+1 modulo N; the
    // requesting master with the smallest distance wins. Distances are
    // unique, so at most one master is ever selected.
    always_comb begin
        o_grant    = '0;
        o_idx      = '0;
        o_any      = 1'b0;
        w_dist     = 0;
        w_bestDist = N;
        for (int i = 0; i < N; i++) begin
            w_dist = i - int'(i_last) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + N;
            end
            if (i_req[i] && (w_dist < w_bestDist)) begin
                w_bestDist = w_dist;
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_idx      = SEL_W'(i);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_merge_rr.sv
// -----------------------------------------------------------------------------
// iob_merge_rr
// Merges N_MASTERS native-bus masters onto one native slave (normally the L2)
// with fair round-robin arbitration, and sequences L2 invalidates so they are
// only issued while no transaction is in flight.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   m_req         N_MASTERS packed {valid, addr, wdata, wstrb}, master 0 LSBs
//   m_resp        N_MASTERS packed {rdata, ready}
//   s_req         request forwarded to the slave (zero while idle)
//   s_resp        slave {rdata, ready}
//   inv_in        invalidate request pulse
//   s_force_inv   one-cycle invalidate strobe to the slave
//   inv_pending   invalidate latched but not yet issued
//   grant         one-hot owner of the slave bus, zero when idle
// -----------------------------------------------------------------------------
module iob_merge_rr
    import iob_merge_rr_pkg::*;
#(
    parameter int  N_MASTERS = 2,
    parameter int  ADDR_W    = 32,
    parameter int  DATA_W    = 32,
    localparam int REQ_W     = calc_req_w(ADDR_W, DATA_W),
    localparam int RESP_W    = calc_resp_w(DATA_W),
    localparam int SEL_W     = calc_sel_w(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    input  logic                          inv_in,
    output logic                          s_force_inv,
    output logic                          inv_pending,
    output logic [N_MASTERS-1:0]          grant
);

    merge_state_t           r_state;
    merge_state_t           w_stateNext;
    logic [SEL_W-1:0]       r_sel;
    logic [SEL_W-1:0]       r_last;
    logic [N_MASTERS-1:0]   r_grant;
    logic                   r_invPending;

    logic [N_MASTERS-1:0]   w_valid;
    logic [N_MASTERS-1:0]   w_winOneHot;
    logic [SEL_W-1:0]       w_winIdx;
    logic                   w_winAny;
    logic [REQ_W-1:0]       w_selReq;
    logic                   w_selValid;
    logic                   w_sReady;
    logic [DATA_W-1:0]      w_rdata;
    logic                   w_loadSel;
    logic                   w_done;
    logic                   w_forceInv;

    // Pull the valid bit (top of each request word) out of every master.
    for (genvar g = 0; g < N_MASTERS; g++) begin : g_valid
        assign w_valid[g] = m_req[g*REQ_W + REQ_W - 1];
    end

    iob_rr_arbiter #(
        .N     (N_MASTERS),
        .SEL_W (SEL_W)
    ) u_arbiter (
        .i_req   (w_valid),
        .i_last  (r_last),
        .o_grant (w_winOneHot),
        .o_idx   (w_winIdx),
        .o_any   (w_winAny)
    );

    // Request mux for the current owner, built as a compare-per-master so
    // the selector never becomes a variable part-select.
    always_comb begin
        w_selReq = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_selReq = m_req[i*REQ_W +: REQ_W];
            end
        end
    end

    assign w_selValid = w_selReq[REQ_W-1];
    assign w_sReady   = s_resp[0];
    assign w_rdata    = s_resp[RESP_W-1:1];

    // Next-state logic. In IDLE a pending invalidate wins over any new grant;
    // in BUSY a dropped valid is an abort and takes precedence over ready, so
    // an aborting master never sees a ready pulse.
    always_comb begin
        w_stateNext = r_state;
        w_loadSel   = 1'b0;
        w_done      = 1'b0;
        w_forceInv  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_invPending) begin
                    w_forceInv = 1'b1;
                end else if (w_winAny) begin
                    w_loadSel   = 1'b1;
                    w_stateNext = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_selValid) begin
                    w_stateNext = ST_IDLE;
                end else if (w_sReady) begin
                    w_done      = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // FSM state, owner registers and grant. last only moves on a completed
    // transfer so an aborted master keeps its place in the rotation. Reset
    // points last at the top master so master 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_last  <= SEL_W'(N_MASTERS - 1);
            r_grant <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_loadSel) begin
                r_sel   <= w_winIdx;
                r_grant <= w_winOneHot;
            end else if (w_stateNext == ST_IDLE) begin
                r_grant <= '0;
            end
            if (w_done) begin
                r_last <= r_sel;
            end
        end
    end

    // Invalidate latch: a new request sets it in any state, and one arriving
    // in the strobe cycle re-arms it so a second strobe follows. Requests
    // while already pending merge into the single outstanding strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_invPending <= 1'b0;
        end else begin
            r_invPending <= inv_in | (r_invPending & ~w_forceInv);
        end
    end

    // Read data is broadcast; ready reaches only the owner, and only on a
    // genuine completion.
    for (genvar g = 0; g < N_MASTERS; g++) begin : g_resp
        assign m_resp[g*RESP_W +: RESP_W] = {w_rdata, w_done & r_grant[g]};
    end

    assign s_req       = (r_state == ST_BUSY) ? w_selReq : '0;
    assign s_force_inv = w_forceInv;
    assign inv_pending = r_invPending;
    assign grant       = r_grant;

endmodule

// File: doc/iob_merge_rr.md
# iob_merge_rr

Parametrised successor to the fixed two-master cache back-end merge in the external-memory subsystem. It merges `N_MASTERS` native-bus masters (L1 instruction and data back-ends, DMA, accelerators) onto one native slave, normally the L2 cache. Arbitration is fair round-robin. It also owns the L2 invalidate sequencing: an invalidate request is held pending and issued to the slave only when no transaction is in flight.

## Interface
Parameters:
- `N_MASTERS`, default 2: number of masters, 1..16.
- `ADDR_W`, default 32: native word-address width.
- `DATA_W`, default 32: data width; strobe width is `DATA_W/8`.

Derived values:
- `REQ_W = 1+ADDR_W+DATA_W+DATA_W/8`.
- `RESP_W = DATA_W+1`.
- `SEL_W = max(1, clog2(N_MASTERS))`.

Ports (clock and reset first):
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `m_req`  in  `N_MASTERS*REQ_W`  packed master requests `{valid, addr, wdata, wstrb}`; master 0 in the LSBs.
- `m_resp`  out  `N_MASTERS*RESP_W`  packed master responses `{rdata, ready}`.
- `s_req`  out  `REQ_W`  slave request.
- `s_resp`  in  `RESP_W`  slave response.
- `inv_in`  in  1  invalidate request pulse (from the L1 data-cache `force_inv_out`).
- `s_force_inv`  out  1  one-cycle invalidate strobe to the slave.
- `inv_pending`  out  1  an invalidate is latched but not yet issued.
- `grant`  out  `N_MASTERS`  one-hot owner of the slave bus; zero when idle.

## Operation
- States are `IDLE`, `BUSY`.
- `IDLE`:
  - If `inv_pending` is set: assert `s_force_inv` for one cycle, clear the pending flag, grant nothing this cycle. Invalidate has priority over new grants.
  - Otherwise, if any master valid is high: select the first valid master searching from `last+1` and wrapping modulo `N_MASTERS`. Register `sel`, set `grant[sel]`, go to `BUSY`.
- `BUSY`:
  - `s_req` equals `m_req[sel]`. `s_req.valid` equals `m_valid[sel]`.
  - On `s_ready`: pulse `m_resp[sel].ready`, set `last <= sel`, go to `IDLE`.
  - If `m_valid[sel]` drops before `s_ready`: treat as an abort, go to `IDLE` with no ready pulse, and leave `last` unchanged.
- `s_resp.rdata` is broadcast to all masters. `ready` is routed only to `sel`; every other master sees `ready` = 0.
- `inv_in`:
  - Sets the pending flag in any state.
  - A new `inv_in` while already pending is absorbed; one strobe is issued.
  - `inv_in` together with the strobe cycle re-arms the flag, so a second strobe follows.
- In `IDLE`, `s_req` is all zeros.
- Reset: state `IDLE`, `last = N_MASTERS-1` so master 0 wins first, `inv_pending` = 0, `grant` = 0, `s_req` = 0, all `m_resp.ready` = 0, `s_force_inv` = 0.
- A reset mid-transaction drops the transaction silently. The slave must also be reset by the same `rst`.

## Timing
- Arbitration takes 1 cycle: a request seen in cycle t is presented on `s_req` in t+1.
- Master ready latency is slave latency + 1 cycle. Ready is combinational from `s_ready` in `BUSY`.
- After each completion there is 1 mandatory `IDLE` cycle. Peak throughput is one transaction per (slave latency + 2) cycles.
- `s_force_inv` goes high in the first `IDLE` cycle with `inv_pending` set. It is never high while `s_req.valid` is high.
- Masters must hold `valid`/`addr`/`wdata`/`wstrb` stable until their `ready`.
- Fairness bound: each requesting master is granted within `N_MASTERS` transactions, plus at most one invalidate cycle per grant.

## Structure
- Shared header (with `iob_intercon.vh`) holds:
  - `REQ_W`/`RESP_W` field macros;
  - `valid`/`address`/`wdata`/`wstrb`/`rdata`/`ready` slicing macros, parametrised by `ADDR_W` and `DATA_W`;
  - state encodings `ST_IDLE`, `ST_BUSY`.
- Sub-module `iob_rr_arbiter` is combinational. Inputs: request vector and `last`. Outputs: one-hot winner, encoded index, `any`. It is reused by other interconnects.
- The top holds the FSM, `sel`/`last` registers, the invalidate latch and the response routing.

## Test plan
- Single request: `N_MASTERS`=2, master 1 reads addr 0x40, slave `ready` 2 cycles later with rdata 0xDEADBEEF. Expect `s_req.valid` 1 cycle after the request, master 1 ready+rdata, master 0 ready = 0.
- Fairness: `N_MASTERS`=4, all valid continuously. Expect grant order 0,1,2,3,0,... and each grant separated by ≥1 `IDLE` cycle.
- Invalidate during traffic: `inv_in` pulsed while master 0 is `BUSY`. Expect `s_force_inv` exactly once, in the `IDLE` cycle after master 0's ready, before the next grant.
- Invalidate collision: `inv_in` held high 3 cycles while idle. Expect strobes on the cycle after the first `inv_in` and again immediately after; never overlapping `s_req.valid`.
- Abort and reset: master 2 drops `valid` in `BUSY`, expect return to `IDLE`, no ready, `last` unchanged. Assert `rst` in `BUSY`, expect all outputs 0 next cycle and master 0 granted first afterwards.
